layer1_disc_stream_adapter: RTL and testbench
=============================================

Name: layer1_disc_stream_adapter

Overview:
Stream-side counterpart of the discriminator layer-1 MAC engine. It packs a valid/ready stream of Q8.8 activations into the engine's flattened input bus and issues the one-cycle start. It waits for the engine's done pulse, captures the flattened output bus, and replays it as a valid/ready stream. It is the only block that drives the engine's start and input bus and the only consumer of its done and output bus.

Parameters:
N_IN, 256, input elements per frame (engine fan-in)
N_OUT, 128, output elements per frame (engine neuron count)
DW, 16, element width, signed Q8.8
TIMEOUT_CYCLES, 40000, watchdog limit in WAIT; used only with ADAPTER_TIMEOUT_EN

Ports:
clk  in  1  clock
rst_n  in  1  reset: one clock; reset is synchronous and active-low
s_valid  in  1  input element valid
s_ready  out  1  adapter accepts input element
s_data  in  DW  input element, Q8.8
s_last  in  1  marks final element of the input frame
layer_start  out  1  one-cycle start pulse to the engine
layer_input_flat  out  DW*N_IN  packed input bus; element k at bits [(k+1)*DW-1 -: DW]
layer_output_flat  in  DW*N_OUT  engine result bus, same packing
layer_done  in  1  engine one-cycle completion pulse
m_valid  out  1  output element valid
m_ready  in  1  downstream accepts output element
m_data  out  DW  output element, Q8.8
m_last  out  1  marks output element N_OUT-1
busy  out  1  high in every state except LOAD
err_frame  out  1  sticky framing error
err_timeout  out  1  sticky watchdog flag; tied 0 without macro

Behaviour:
- Reset (rst_n=0 at posedge): state=LOAD, all counters=0, layer_input_flat=0, the output capture buffer=0, s_ready=0 for that cycle, then 1 in LOAD, layer_start=0, m_valid=0, m_data=0, m_last=0, busy=0, err_frame=0, err_timeout=0. Reset during any state aborts the frame. A layer_done arriving after the abort is ignored.
- LOAD: s_ready=1.
  - Each handshake writes s_data to element in_idx, then in_idx increments.
  - Frame ends at the handshake with in_idx=N_IN-1 or with s_last=1, whichever comes first.
  - s_last before N_IN-1: remaining elements are zero. layer_input_flat is cleared when LOAD is entered. Set err_frame.
  - N_IN-1 reached without s_last: set err_frame; the frame still ends.
  - At frame end, go to FIRE.
- FIRE (one cycle): layer_start=1 and s_ready=0. layer_start rises the cycle after the final input handshake. Next state is WAIT.
- WAIT: layer_start=0.
  - layer_input_flat must be held bit-stable, because the engine reads it combinationally for its full 32768-cycle run.
  - On layer_done=1, copy layer_output_flat into the capture buffer on the same edge. Go to DRAIN with out_idx=0.
- DRAIN: m_valid=1 and m_data=buffer element out_idx. m_last=(out_idx==N_OUT-1).
  - m_data and m_last hold while m_valid&&!m_ready.
  - Each handshake increments out_idx. Back-to-back beats are allowed, one per cycle.
  - On the handshake with m_last, set m_valid=0, go to LOAD, clear in_idx and layer_input_flat, and set s_ready=1 the next cycle.
- layer_done outside WAIT is ignored. s_valid outside LOAD is ignored (s_ready=0).
- err flags clear only on reset.
- No arithmetic on the data; elements pass through bit-exact.

Optional Feature:
ADAPTER_TIMEOUT_EN.
- Defined: a counter runs in WAIT. If it reaches TIMEOUT_CYCLES without layer_done, then:
  - set err_timeout;
  - drop the frame and produce no output beats;
  - go to LOAD with normal LOAD-entry clearing.
  - The counter clears on entering WAIT.
- Undefined: WAIT has no limit, there is no counter logic, and err_timeout is constant 0.

Test Plan:
1. Send 256 beats with s_data=k, k=0..255, and s_last on beat 255 → element k of layer_input_flat = k. layer_start is high exactly one cycle, the cycle after beat 255. s_ready=0 and busy=1 from then on. err_frame=0.
2. Engine model asserts layer_done 10 cycles after start, with element j=0x0100+j; m_ready held 1 → 128 consecutive beats, m_data=0x0100+j, m_last only on beat 127. s_ready=1 the cycle after.
3. Same frame with m_ready toggling each cycle → m_data and m_last stable while stalled. Exactly 128 beats, no loss or duplication.
4. s_last on beat 9 (values 1..10) → elements 0..9 = 1..10, elements 10..255 = 0, err_frame=1, layer_start pulses once.
5. rst_n=0 for one cycle in WAIT, then layer_done pulses → all outputs at reset values, no m_valid, adapter back in LOAD accepting beats.
6. With ADAPTER_TIMEOUT_EN and TIMEOUT_CYCLES=50, layer_done never arrives → err_timeout=1 after 50 WAIT cycles, no output beats, s_ready=1. Without the macro the adapter stays in WAIT.

Source files
------------

// File: rtl/layer1_disc_stream_adapter.sv
// Stream adapter for the discriminator layer-1 MAC engine: packs an input frame, fires the
// engine, captures its result and replays it as a stream. Optional watchdog: ADAPTER_TIMEOUT_EN.
module layer1_disc_stream_adapter #(
    parameter int unsigned N_IN           = 256,
    parameter int unsigned N_OUT          = 128,
    parameter int unsigned DW             = 16,
    parameter int unsigned TIMEOUT_CYCLES = 40000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DW-1:0]       s_data,
    input  logic                s_last,
    output logic                layer_start,
    output logic [DW*N_IN-1:0]  layer_input_flat,
    input  logic [DW*N_OUT-1:0] layer_output_flat,
    input  logic                layer_done,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DW-1:0]       m_data,
    output logic                m_last,
    output logic                busy,
    output logic                err_frame,
    output logic                err_timeout
);

    localparam int unsigned InIdxW  = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned OutIdxW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [InIdxW-1:0]  InLast  = InIdxW'(N_IN - 1);
    localparam logic [OutIdxW-1:0] OutLast = OutIdxW'(N_OUT - 1);

    typedef enum logic [1:0] {StLoad, StFire, StWait, StDrain} state_e;

    state_e               state_q, state_d;
    logic [InIdxW-1:0]    in_idx_q;
    logic [OutIdxW-1:0]   out_idx_q;
    logic [DW*N_IN-1:0]   in_flat_q;
    logic [DW*N_OUT-1:0]  out_buf_q;
    logic                 err_frame_q;

    logic s_hs, in_end, m_hs, out_end, timeout_hit, load_entry;

    assign s_hs       = s_valid && s_ready;
    assign in_end     = s_hs && (s_last || (in_idx_q == InLast));
    assign m_hs       = m_valid && m_ready;
    assign out_end    = m_hs && m_last;
    assign load_entry = out_end || timeout_hit;

    assign layer_input_flat = in_flat_q;
    assign err_frame        = err_frame_q;

`ifdef ADAPTER_TIMEOUT_EN
    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TimerW-1:0] timer_q;
    logic              err_timeout_q;

    assign timeout_hit = (state_q == StWait) && !layer_done &&
                         (timer_q == TimerW'(TIMEOUT_CYCLES - 1));
    assign err_timeout = err_timeout_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_q       <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            if (state_q == StFire) begin
                timer_q <= '0;
            end else if (state_q == StWait) begin
                timer_q <= timer_q + 1'b1;
            end
            if (timeout_hit) begin
                err_timeout_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StLoad;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StLoad:  if (in_end) state_d = StFire;
            StFire:  state_d = StWait;
            StWait: begin
                if (layer_done) begin
                    state_d = StDrain;
                end else if (timeout_hit) begin
                    state_d = StLoad;
                end
            end
            StDrain: if (out_end) state_d = StLoad;
            default: state_d = StLoad;
        endcase
    end

    always_comb begin
        s_ready     = 1'b0;
        layer_start = 1'b0;
        m_valid     = 1'b0;
        m_data      = '0;
        m_last      = 1'b0;
        busy        = 1'b1;
        case (state_q)
            StLoad: begin
                s_ready = rst_n;
                busy    = 1'b0;
            end
            StFire: layer_start = 1'b1;
            StDrain: begin
                m_valid = 1'b1;
                m_data  = out_buf_q[out_idx_q*DW +: DW];
                m_last  = (out_idx_q == OutLast);
            end
            default: ;
        endcase
    end

    // Input bus only changes in LOAD, so it stays bit-stable for the whole engine run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_idx_q    <= '0;
            out_idx_q   <= '0;
            in_flat_q   <= '0;
            out_buf_q   <= '0;
            err_frame_q <= 1'b0;
        end else begin
            if (load_entry) begin
                in_idx_q  <= '0;
                in_flat_q <= '0;
            end else if (s_hs) begin
                in_flat_q[in_idx_q*DW +: DW] <= s_data;
                if (!in_end) begin
                    in_idx_q <= in_idx_q + 1'b1;
                end
                if (s_last != (in_idx_q == InLast)) begin
                    err_frame_q <= 1'b1;
                end
            end

            if ((state_q == StWait) && layer_done) begin
                out_buf_q <= layer_output_flat;
                out_idx_q <= '0;
            end else if (m_hs) begin
                out_idx_q <= out_end ? '0 : out_idx_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_layer1_disc_stream_adapter.sv
// Directed bench for layer1_disc_stream_adapter: frame packing, drain with and without
// backpressure, short frames, reset abort and the optional WAIT watchdog.
module tb_layer1_disc_stream_adapter;

    localparam int N_IN  = 256;
    localparam int N_OUT = 128;
    localparam int DW    = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                s_valid;
    logic                s_ready;
    logic [DW-1:0]       s_data;
    logic                s_last;
    logic                layer_start;
    logic [DW*N_IN-1:0]  layer_input_flat;
    logic [DW*N_OUT-1:0] layer_output_flat;
    logic                layer_done;
    logic                m_valid;
    logic                m_ready;
    logic [DW-1:0]       m_data;
    logic                m_last;
    logic                busy;
    logic                err_frame;
    logic                err_timeout;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    layer1_disc_stream_adapter #(
        .N_IN          (N_IN),
        .N_OUT         (N_OUT),
        .DW            (DW),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_data           (s_data),
        .s_last           (s_last),
        .layer_start      (layer_start),
        .layer_input_flat (layer_input_flat),
        .layer_output_flat(layer_output_flat),
        .layer_done       (layer_done),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_data           (m_data),
        .m_last           (m_last),
        .busy             (busy),
        .err_frame        (err_frame),
        .err_timeout      (err_timeout)
    );

    // Stimulus only: called at a negedge, returns at the negedge after the last handshake.
    task automatic send_beats(input int n, input int first, input int last_at);
        for (int k = 0; k < n; k++) begin
            s_valid = 1'b1;
            s_data  = DW'(first + k);
            s_last  = (k == last_at);
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Engine model: loads the result bus, then pulses done after `delay` cycles.
    task automatic engine_done(input int delay, input int base);
        for (int j = 0; j < N_OUT; j++) layer_output_flat[j*DW +: DW] = DW'(base + j);
        repeat (delay) @(negedge clk);
        layer_done = 1'b1;
        @(negedge clk);
        layer_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        layer_done = 1'b0; layer_output_flat = '0; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
        n_vec++; if ({layer_start, m_valid, m_last, busy, err_frame, err_timeout} !== 6'b0) begin
            n_err++; $display("FAIL reset_flags: got %b want 000000",
                              {layer_start, m_valid, m_last, busy, err_frame, err_timeout});
        end
        n_vec++; if (m_data !== '0) begin n_err++; $display("FAIL reset_m_data: got %h want 0", m_data); end
        n_vec++; if (layer_input_flat !== '0) begin n_err++; $display("FAIL reset_flat: got nonzero want 0"); end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL load_s_ready: got %b want 1", s_ready); end
    endtask

    task automatic test_full_frame();
        logic [DW-1:0] got;
        send_beats(N_IN, 0, N_IN - 1);
        n_vec++; if (layer_start !== 1'b1) begin n_err++; $display("FAIL start_pulse: got %b want 1", layer_start); end
        n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL fire_s_ready: got %b want 0", s_ready); end
        @(negedge clk);
        n_vec++; if (layer_start !== 1'b0) begin n_err++; $display("FAIL start_width: got %b want 0", layer_start); end
        n_vec++; if ({s_ready, busy, err_frame} !== 3'b010) begin
            n_err++; $display("FAIL wait_flags: got %b want 010", {s_ready, busy, err_frame});
        end
        for (int k = 0; k < N_IN; k++) begin
            got = layer_input_flat[k*DW +: DW];
            n_vec++; if (got !== DW'(k)) begin n_err++; $display("FAIL full_elem[%0d]: got %h want %h", k, got, DW'(k)); end
        end
    endtask

    task automatic test_drain();
        int beats = 0;
        int gaps = 0;
        m_ready = 1'b1;
        engine_done(9, 'h100);
        for (int c = 0; c < 400 && beats < N_OUT; c++) begin
            if (m_valid) begin
                n_vec++; if (m_data !== DW'('h100 + beats)) begin
                    n_err++; $display("FAIL drain_data[%0d]: got %h want %h", beats, m_data, DW'('h100 + beats));
                end
                n_vec++; if (m_last !== (beats == N_OUT - 1)) begin
                    n_err++; $display("FAIL drain_last[%0d]: got %b want %b", beats, m_last, beats == N_OUT - 1);
                end
                beats++;
            end else begin
                gaps++;
            end
            @(negedge clk);
        end
        n_vec++; if (beats !== N_OUT) begin n_err++; $display("FAIL drain_count: got %0d want %0d", beats, N_OUT); end
        n_vec++; if (gaps !== 0) begin n_err++; $display("FAIL drain_gaps: got %0d want 0", gaps); end
        n_vec++; if ({m_valid, s_ready, busy} !== 3'b010) begin
            n_err++; $display("FAIL drain_end: got %b want 010", {m_valid, s_ready, busy});
        end
    endtask

    task automatic test_backpressure();
        int beats = 0;
        logic stalled = 1'b0;
        logic [DW-1:0] prev_data = '0;
        logic prev_last = 1'b0;
        send_beats(N_IN, 0, N_IN - 1);
        engine_done(10, 'h100);
        for (int c = 0; c < 600 && beats < N_OUT; c++) begin
            if (stalled) begin
                n_vec++; if ({m_valid, m_data, m_last} !== {1'b1, prev_data, prev_last}) begin
                    n_err++; $display("FAIL stall_hold: got %b/%h/%b want 1/%h/%b",
                                      m_valid, m_data, m_last, prev_data, prev_last);
                end
            end
            m_ready = c[0];
            if (m_valid && m_ready) begin
                n_vec++; if (m_data !== DW'('h100 + beats)) begin
                    n_err++; $display("FAIL bp_data[%0d]: got %h want %h", beats, m_data, DW'('h100 + beats));
                end
                n_vec++; if (m_last !== (beats == N_OUT - 1)) begin
                    n_err++; $display("FAIL bp_last[%0d]: got %b want %b", beats, m_last, beats == N_OUT - 1);
                end
                beats++;
            end
            stalled   = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
            @(negedge clk);
        end
        n_vec++; if (beats !== N_OUT) begin n_err++; $display("FAIL bp_count: got %0d want %0d", beats, N_OUT); end
        n_vec++; if ({m_valid, s_ready} !== 2'b01) begin
            n_err++; $display("FAIL bp_end: got %b want 01", {m_valid, s_ready});
        end
        m_ready = 1'b1;
    endtask

    task automatic test_short_frame();
        int starts = 0;
        logic [DW-1:0] got;
        send_beats(10, 1, 9);
        for (int c = 0; c < 6; c++) begin
            if (layer_start) starts++;
            @(negedge clk);
        end
        n_vec++; if (starts !== 1) begin n_err++; $display("FAIL short_starts: got %0d want 1", starts); end
        n_vec++; if (err_frame !== 1'b1) begin n_err++; $display("FAIL short_err_frame: got %b want 1", err_frame); end
        for (int k = 0; k < N_IN; k++) begin
            got = layer_input_flat[k*DW +: DW];
            n_vec++; if (got !== ((k < 10) ? DW'(k + 1) : DW'(0))) begin
                n_err++; $display("FAIL short_elem[%0d]: got %h want %h", k, got, (k < 10) ? DW'(k + 1) : DW'(0));
            end
        end
    endtask

    task automatic test_reset_in_wait();
        int valids = 0;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL pre_abort_busy: got %b want 1", busy); end
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++; if ({s_ready, busy, layer_start, m_valid, m_last, err_frame, err_timeout} !== 7'b0) begin
            n_err++; $display("FAIL abort_flags: got %b want 0000000",
                              {s_ready, busy, layer_start, m_valid, m_last, err_frame, err_timeout});
        end
        n_vec++; if ({m_data, layer_input_flat} !== '0) begin n_err++; $display("FAIL abort_data: got nonzero want 0"); end
        rst_n = 1'b1;
        for (int j = 0; j < N_OUT; j++) layer_output_flat[j*DW +: DW] = DW'('h5A00 + j);
        layer_done = 1'b1;
        @(negedge clk);
        layer_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (m_valid) valids++;
            @(negedge clk);
        end
        n_vec++; if (valids !== 0) begin n_err++; $display("FAIL stale_done_beats: got %0d want 0", valids); end
        n_vec++; if ({s_ready, busy} !== 2'b10) begin
            n_err++; $display("FAIL post_abort_load: got %b want 10", {s_ready, busy});
        end
    endtask

    task automatic test_timeout();
        int valids = 0;
        logic [DW-1:0] got;
        send_beats(3, 7, 2);
        n_vec++; if (layer_start !== 1'b1) begin n_err++; $display("FAIL to_start: got %b want 1", layer_start); end
        for (int k = 0; k < 4; k++) begin
            got = layer_input_flat[k*DW +: DW];
            n_vec++; if (got !== ((k < 3) ? DW'(7 + k) : DW'(0))) begin
                n_err++; $display("FAIL to_elem[%0d]: got %h want %h", k, got, (k < 3) ? DW'(7 + k) : DW'(0));
            end
        end
`ifdef ADAPTER_TIMEOUT_EN
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (m_valid) valids++;
        end
        n_vec++; if ({busy, err_timeout} !== 2'b10) begin
            n_err++; $display("FAIL to_cycle50: got %b want 10", {busy, err_timeout});
        end
        @(negedge clk);
        n_vec++; if ({busy, err_timeout, s_ready} !== 3'b011) begin
            n_err++; $display("FAIL to_expired: got %b want 011", {busy, err_timeout, s_ready});
        end
        n_vec++; if (layer_input_flat !== '0) begin n_err++; $display("FAIL to_flat_clear: got nonzero want 0"); end
`else
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (m_valid) valids++;
        end
        n_vec++; if ({busy, err_timeout, s_ready} !== 3'b100) begin
            n_err++; $display("FAIL no_to_wait: got %b want 100", {busy, err_timeout, s_ready});
        end
`endif
        n_vec++; if (valids !== 0) begin n_err++; $display("FAIL to_beats: got %0d want 0", valids); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_drain();
        test_backpressure();
        test_short_frame();
        test_reset_in_wait();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
